// File: rtl/inst_loader.sv
// inst_loader: serial program loader for the instruction memory of the core.
// Receives a framed image over an 8N1 UART line:
//   0xA5, L, 4*(L+1) data bytes (little-endian words), XOR checksum.
// Each assembled word is written into instruction memory. The core is held
// in reset until a complete image with a good checksum has been written.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx         UART receive line (asynchronous, idle high)
//   mem_we     one-cycle write strobe to instruction memory
//   mem_addr   word address of the current write
//   mem_wdata  instruction word to write
//   core_rst   high while the core must not run (low only after a good load)
//   done       last load completed with a good checksum
//   err        last load aborted (framing or checksum error)
module inst_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  // The start-edge detector sees rx two cycles late, so the mid-bit sample of
  // the start bit is taken two counts short of CLKS_PER_BIT/2 after arming.
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2 - 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;

  logic             rx_p0, rx_p1, rx_p2;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             frm_err;
  logic             bit_tick;

  state_t           state;
  logic [7:0]       len;
  logic [7:0]       wcnt;
  logic [1:0]       bcnt;
  logic [7:0]       xsum;
  logic [23:0]      word_lo;

  assign bit_tick = (cnt == BIT_LAST);

  // Stage p0/p1: synchronizer; p2: delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      rx_p2      <= 1'b1;
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      rx_p0      <= rx;
      rx_p1      <= rx_p0;
      rx_p2      <= rx_p1;
      byte_valid <= 1'b0;
      frm_err    <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_p2 && !rx_p1) rx_state <= RX_START;
        end
        RX_START: begin
          if (cnt == START_LAST) begin
            cnt      <= '0;
            // A start bit that reads high again was only a glitch.
            rx_state <= rx_p1 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (bit_tick) begin
            cnt        <= '0;
            rx_state   <= RX_IDLE;
            byte_valid <= rx_p1;
            frm_err    <= !rx_p1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Data-only registers: receive shifter (LSB first) and low bytes of a word
  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && bit_tick) rx_byte <= {rx_p1, rx_byte[7:1]};
    if (state == DATA && byte_valid) begin
      case (bcnt)
        2'd0:    word_lo[7:0]   <= rx_byte;
        2'd1:    word_lo[15:8]  <= rx_byte;
        default: word_lo[23:16] <= rx_byte;
      endcase
    end
  end

  // Loader FSM: consumes byte_valid / frm_err from the receiver
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      wcnt      <= '0;
      bcnt      <= '0;
      xsum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_rst  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      // Address advances on the edge after the write strobe.
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
      if (frm_err) begin
        if (state != IDLE) begin
          state    <= ERR;
          core_rst <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b1;
        end
      end else if (byte_valid) begin
        case (state)
          LEN: begin
            len   <= rx_byte;
            wcnt  <= '0;
            bcnt  <= '0;
            xsum  <= '0;
            state <= DATA;
          end
          DATA: begin
            xsum <= xsum ^ rx_byte;
            bcnt <= bcnt + 1'b1;
            if (bcnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {rx_byte, word_lo};
              wcnt      <= wcnt + 8'd1;
              if (wcnt == len) state <= CHK;
            end
          end
          CHK: begin
            if (rx_byte == xsum) begin
              state    <= DONE;
              core_rst <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
          default: begin
            // IDLE, DONE and ERR all restart on a header and ignore anything else.
            if (rx_byte == 8'hA5) begin
              state    <= LEN;
              mem_addr <= '0;
              core_rst <= 1'b1;
              done     <= 1'b0;
              err      <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Serial program loader sitting directly upstream of the single-cycle RISC-V core's instruction memory. It receives a framed program image over a UART line, assembles little-endian 32-bit words, and issues one write per word into the instruction ROM's write port. The core is held in reset while a load is in progress. Reset is released only after a complete, checksum-verified image has been written.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4.
- ADDR_W, 8: instruction-memory word-address width; matches the ROM index PC[9:2].

Ports:
- clk  in  1  system clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  UART receive line, asynchronous to clk, idle high.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_W  word address of the current write.
- mem_wdata  out  32  instruction word to write.
- core_rst  out  1  reset request to the core; high while the core must not run.
- done  out  1  last load completed with a good checksum.
- err  out  1  last load aborted (framing or checksum error).

## Operation
- rx passes through a 2-FF synchronizer before any use.
- UART receiver, 8N1 framing:
  - A falling edge on the synchronized rx arms the receiver.
  - The start bit is re-sampled at CLKS_PER_BIT/2. If it reads high, the edge is treated as a glitch and the receiver returns to idle.
  - 8 data bits are sampled, LSB first, each CLKS_PER_BIT after the previous sample.
  - The stop bit is sampled one further CLKS_PER_BIT later.
  - Stop bit = 1: emit a one-cycle byte_valid with the byte.
  - Stop bit = 0: framing error.
- Frame format, in order:
  - Header byte 0xA5.
  - Length byte L; the image is L+1 words (1..256).
  - 4·(L+1) data bytes, little-endian per word: first byte → [7:0], fourth byte → [31:24].
  - Checksum byte equal to the XOR of all data bytes.
- Loader FSM states: IDLE, LEN, DATA, CHK, DONE, ERR.
  - IDLE: bytes other than 0xA5 are ignored. 0xA5 → LEN.
  - LEN: store L; clear the word counter, byte counter and running XOR → DATA.
  - DATA: shift each byte into the word assembler and fold it into the XOR.
    - On the 4th byte of a word: present the word and address, pulse mem_we, increment the address.
    - After word L is written → CHK.
  - CHK: byte equals the running XOR → DONE. Otherwise → ERR.
  - DONE and ERR: a 0xA5 header → LEN, restarting the load. Other bytes are ignored.
  - A framing error in any state except IDLE → ERR. In IDLE, a framing error is dropped silently.
- Outputs per state:
  - core_rst = 1 in IDLE, LEN, DATA, CHK and ERR; 0 only in DONE.
  - done = 1 only in DONE.
  - err = 1 only in ERR.
  - Entering LEN clears both done and err.
- Words already written when an abort occurs are left in memory. core_rst remains high, so the partial image never executes.
- mem_addr starts at 0 for every frame and wraps naturally at 2^ADDR_W. With ADDR_W=8 a 256-word image ends at address 255 with no wrap.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, err=0. FSM is in IDLE; receiver is idle and its counters are cleared.
- rst has priority over every other event on the same edge. Asserting rst mid-byte or mid-frame discards all partial state. The next frame must begin with a fresh header.
- Delay from rx edge to internal view: 2 cycles of synchronizer.
- byte_valid: asserted on the cycle after the stop-bit sample.
- mem_we: asserted on the cycle after byte_valid of the word's 4th byte. It is high for exactly 1 cycle, with mem_addr and mem_wdata stable during that cycle. mem_addr increments on the following edge.
- core_rst falls, and done rises, on the cycle after byte_valid of a correct checksum byte.
- err rises on the cycle after the offending byte_valid or framing-error detection.
- Back-to-back bytes with zero idle time between stop and start bits are supported. Receiver turnaround is at most one bit period.

## Test plan
- Single-word load, CLKS_PER_BIT=4. Send A5 00 13 05 A0 00 B6 → one mem_we with addr 0, wdata 0x00A00513. Then done=1 and core_rst=0.
- Three-word load (L=2), words 0x11111111, 0x22222222, 0x33333333, correct XOR 0x00 → mem_we at addrs 0, 1, 2 with those values. done=1.
- Checksum mismatch: same frame as above but checksum 0xFF → all 3 writes occur, then err=1, core_rst stays 1, done=0.
- Framing error: stop bit forced low on the 2nd data byte → err=1 and no mem_we for that word. A following valid frame ends with done=1 and err=0.
- Reset mid-load: assert rst for 1 cycle after 5 data bytes → all outputs return to reset values. A fresh frame then loads from addr 0.
- Reload after DONE: a second header A5 causes core_rst to rise on the cycle after that byte_valid, with done cleared. The new image overwrites from addr 0.
